// File: rtl/des_round_sequencer_if.sv
// rtl/des_round_sequencer_if.sv - command, key-schedule and f-function signal bundle for the DES round sequencer
interface des_round_sequencer_if;
    logic        start;
    logic        decrypt;
    logic [63:0] data_in;
    logic [3:0]  key_round;
    logic [47:0] sub_key;
    logic [31:0] f_r;
    logic [47:0] f_key;
    logic [31:0] f_out;
    logic        busy;
    logic        done;
    logic [63:0] data_out;

    // Block-level controller plus the external key schedule and f-function
    modport master (
        output start, decrypt, data_in, sub_key, f_out,
        input  key_round, f_r, f_key, busy, done, data_out
    );

    // The round sequencer itself
    modport slave (
        input  start, decrypt, data_in, sub_key, f_out,
        output key_round, f_r, f_key, busy, done, data_out
    );
endinterface

// File: rtl/des_round_sequencer.sv
// rtl/des_round_sequencer.sv - 16-round DES Feistel sequencer with IP/FP and subkey ordering
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    des_round_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // FIPS 46-3 tables, entries are DES bit numbers (1 = MSB)
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9,  49, 17, 57, 25};

    function automatic logic [63:0] ip(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_TAB[i])];
        return o;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_TAB[i])];
        return o;
    endfunction

    state_t      state;
    state_t      state_next;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [3:0]  round_idx;
    logic        mode;
    logic [63:0] data_out_reg;
    logic [63:0] ip_out;
    logic [31:0] r_next;
    logic        last_round;

    assign ip_out     = ip(bus.data_in);
    assign r_next     = l_reg ^ bus.f_out;
    assign last_round = (round_idx == 4'(NUM_ROUNDS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: start only counts in IDLE, DONE lasts exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ROUND;
            ROUND:   if (last_round) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Feistel datapath: load IP(block) on start, one round per edge, FP with final swap on the last edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_reg        <= '0;
            r_reg        <= '0;
            round_idx    <= '0;
            mode         <= 1'b0;
            data_out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        l_reg     <= ip_out[63:32];
                        r_reg     <= ip_out[31:0];
                        mode      <= bus.decrypt;
                        round_idx <= '0;
                    end
                end
                ROUND: begin
                    l_reg     <= r_reg;
                    r_reg     <= r_next;
                    round_idx <= round_idx + 4'd1;
                    if (last_round) data_out_reg <= fp({r_next, r_reg});
                end
                default: ;
            endcase
        end
    end

    // Status, subkey index (reversed for decrypt) and f-function pass-through
    always_comb begin
        bus.busy      = (state == ROUND);
        bus.done      = (state == DONE);
        bus.key_round = 4'd0;
        if (state == ROUND) bus.key_round = mode ? (4'd15 - round_idx) : round_idx;
        bus.f_r       = r_reg;
        bus.f_key     = bus.sub_key;
        bus.data_out  = data_out_reg;
    end
endmodule

// File: tb/tb_des_round_sequencer.sv
// tb/tb_des_round_sequencer.sv - self-checking bench for des_round_sequencer with reference key schedule and f-function
module tb_des_round_sequencer;
    localparam int E_TAB [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
        26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    typedef struct {
        logic [63:0] key;
        logic [63:0] din;
        logic        dec;
        logic [63:0] expect_out;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [47:0] ks [16];
    int          n_checks;
    int          n_fail;
    vec_t        vecs [6];

    des_round_sequencer_if bus();

    des_round_sequencer #(.NUM_ROUNDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        int          idx;
        e = '0;
        s = '0;
        o = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_TAB[i])];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = e[47 - 6 * b -: 6];
            idx = b * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            s[31 - 4 * b -: 4] = 4'(SBOX[idx]);
        end
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_TAB[i])];
        return o;
    endfunction

    task automatic load_key(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cat;
        logic [47:0] sk;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cat = {c, d};
            sk = '0;
            for (int i = 0; i < 48; i++) sk[6'(47 - i)] = cat[6'(56 - PC2_TAB[i])];
            ks[r] = sk;
        end
    endtask

    assign bus.sub_key = ks[bus.key_round];
    assign bus.f_out   = des_f(bus.f_r, bus.f_key);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One block through the sequencer with optional mid-block decrypt toggling or a stray start
    task automatic run_block(input logic [63:0] key, input logic [63:0] din, input logic dec,
                             input logic [63:0] exp, input bit toggle, input bit inject);
        int done_at;
        int busy_cnt;
        int extra_done;
        load_key(key);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = din;
        bus.decrypt = dec;
        done_at  = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            bus.start = (inject && k == 5);
            if (inject && k == 5) bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
            if (bus.busy) begin
                check("key_round", 64'(bus.key_round),
                      64'(dec ? (15 - busy_cnt) : busy_cnt));
                busy_cnt++;
            end
            if (bus.done) done_at = k;
            if (toggle) bus.decrypt = ~bus.decrypt;
        end
        bus.start = 1'b0;
        check("done_latency", 64'(done_at), 64'd17);
        check("busy_cycles", 64'(busy_cnt), 64'd16);
        check("data_out", bus.data_out, exp);
        @(negedge clk);
        check("done_width", 64'(bus.done), 64'd0);
        if (inject) begin
            extra_done = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.done) extra_done++;
            end
            check("no_second_done", 64'(extra_done), 64'd0);
            check("data_out_held", bus.data_out, exp);
        end
    endtask

    initial begin
        int done_times [3];
        int n_done;
        n_checks = 0;
        n_fail   = 0;
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.data_in = '0;
        for (int i = 0; i < 16; i++) ks[i] = '0;
        vecs[0] = '{64'h1334_5779_9BBC_DFF1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h85E8_1354_0F0A_B405};
        vecs[1] = '{64'h1334_5779_9BBC_DFF1, 64'h85E8_1354_0F0A_B405, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[2] = '{64'h0E32_9232_EA6D_0D73, 64'h8787_8787_8787_8787, 1'b0, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h0E32_9232_EA6D_0D73, 64'h0000_0000_0000_0000, 1'b1, 64'h8787_8787_8787_8787};
        vecs[4] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 64'h8CA6_4DE9_C1B1_23A7};
        vecs[5] = '{64'h0000_0000_0000_0000, 64'h8CA6_4DE9_C1B1_23A7, 1'b1, 64'h0000_0000_0000_0000};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_data_out", bus.data_out, 64'd0);
        check("rst_key_round", 64'(bus.key_round), 64'd0);
        check("rst_f_r", 64'(bus.f_r), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_block(vecs[v].key, vecs[v].din, vecs[v].dec, vecs[v].expect_out, 1'b0, 1'b0);

        // Stray start while rounds run
        run_block(vecs[0].key, vecs[0].din, 1'b0, vecs[0].expect_out, 1'b0, 1'b1);

        // Decrypt level toggling during ROUND, both latched modes
        run_block(vecs[0].key, vecs[0].din, 1'b0, vecs[0].expect_out, 1'b1, 1'b0);
        run_block(vecs[1].key, vecs[1].din, 1'b1, vecs[1].expect_out, 1'b1, 1'b0);

        // Asynchronous reset in round 8
        load_key(vecs[0].key);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = vecs[0].din;
        bus.decrypt = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_data_out", bus.data_out, 64'd0);
        check("arst_key_round", 64'(bus.key_round), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_block(vecs[2].key, vecs[2].din, vecs[2].dec, vecs[2].expect_out, 1'b0, 1'b0);

        // Start held high: one block per 18 cycles
        load_key(vecs[4].key);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = vecs[4].din;
        bus.decrypt = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 80 && n_done < 3; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_times[n_done] = k;
                n_done++;
                check("b2b_data_out", bus.data_out, vecs[4].expect_out);
                if (n_done == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", 64'(n_done), 64'd3);
        if (n_done == 3) begin
            check("b2b_first_done", 64'(done_times[0]), 64'd17);
            check("b2b_spacing_1", 64'(done_times[1] - done_times[0]), 64'd18);
            check("b2b_spacing_2", 64'(done_times[2] - done_times[1]), 64'd18);
        end
        repeat (3) @(negedge clk);
        check("b2b_idle_after", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/des_round_sequencer.md
# des_round_sequencer

- Drives the 16-round DES Feistel iteration around the existing round-function datapath (expand, subkey XOR, S-box/P).
- Owns the L/R state registers, the initial and final permutations, round counting and encrypt/decrypt subkey ordering.
- The f-function and the key schedule stay external, reached through ports.
- Sits between the block-level command interface (start/done) and the f-function and key-schedule instances.

## Interface
Parameters:
- NUM_ROUNDS, 16, Feistel rounds per block; only 16 is a supported value.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request; sampled only in IDLE
- decrypt  in  1  0 = encrypt, 1 = decrypt; latched on accepted start
- data_in  in  64  plaintext/ciphertext block, bit 63 = DES bit 1; latched on accepted start
- key_round  out  4  subkey index presented to key schedule (0..15)
- sub_key  in  48  subkey K[key_round+1] from key schedule, combinational
- f_r  out  32  current R register value, fed to f-function
- f_key  out  48  sub_key passed through to f-function
- f_out  in  32  f-function result f(R, K), combinational
- busy  out  1  high while rounds execute
- done  out  1  one-cycle pulse when data_out is updated
- data_out  out  64  result block, bit 63 = DES bit 1; held until next completion

## Operation
Reset values:
- Reset forces IDLE.
- L, R, round_idx, data_out = 0.
- busy = 0, done = 0, mode = 0.
- Reset while in ROUND discards the block; no done pulse is produced.

States:
- IDLE
  - busy = 0, done = 0.
  - On start = 1: L||R <= IP(data_in); mode <= decrypt; round_idx <= 0; go to ROUND.
- ROUND
  - busy = 1.
  - Each edge: L <= R; R <= L ^ f_out; round_idx <= round_idx + 1.
  - When round_idx == 15 at the edge: data_out <= FP({L ^ f_out, R}), i.e. the final swap is applied (preoutput R16||L16). Go to DONE; round_idx wraps to 0.
- DONE
  - done = 1, busy = 0, for exactly one cycle; then IDLE.

Subkey ordering:
- key_round = round_idx when mode = 0.
- key_round = 15 - round_idx when mode = 1.
- In IDLE and DONE, key_round = 0.

Combinational pass-through:
- f_r = R; f_key = sub_key.
- No internal arithmetic beyond XOR; widths are exact, no truncation.

Permutations:
- IP and FP are standard FIPS 46-3 tables, implemented as fixed wiring inside this block.

Input handling:
- start in ROUND or DONE is ignored (not queued).
- data_in and decrypt are ignored outside an accepted start.
- The decrypt level after acceptance has no effect on the block in flight.

## Timing
- Accepted start at edge E0, rounds at edges E1..E16.
- data_out is valid and done = 1 in the cycle following E16; done falls at E17.
- busy is high from after E0 through E16, i.e. 16 cycles.
- Latency from the start edge to data_out valid is 16 clocks. Throughput is one block per 18 cycles: start is accepted earliest in the cycle after E17 (IDLE).
- sub_key and f_out must settle within the same cycle as key_round and f_r. No pipeline register on the f-function path.
- data_out changes only at the final-round edge, or on Reset.

## Test plan
- Encrypt known vector: key schedule for key 133457799BBCDFF1, data_in = 0123456789ABCDEF, decrypt = 0 -> after 16 busy cycles data_out = 85E813540F0AB405, done high exactly one cycle.
- Decrypt round-trip: same key, data_in = 85E813540F0AB405, decrypt = 1 -> data_out = 0123456789ABCDEF. key_round sequence observed 15, 14, ..., 0.
- Start while busy: assert start with data_in = FFFFFFFFFFFFFFFF at cycle 5 of a running encrypt -> ignored. Original result 85E813540F0AB405 still produced at the same cycle; no second done.
- Reset mid-operation: Reset asserted asynchronously during round 8 -> immediately busy = 0, done = 0, data_out = 0, key_round = 0. A new start after release yields the correct result with no residue.
- Back-to-back: start held high continuously -> blocks accepted every 18 cycles. done pulses spaced 18 cycles apart, each data_out correct.
- Mode latch: decrypt toggled during ROUND -> key_round order unchanged from the value latched at start.
